dff_posedge_sync: RTL and testbench

DFF_POSEDGE_SYNC -- requirements
Module: dff_posedge_sync

---
 rtl/dff_posedge_sync.sv | 70 +++++++
 tb/tb_dff_posedge_sync.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dff_posedge_sync.sv
// ---------------------------------------------------------------------------
// dff_posedge_sync
//
// Rising-edge D flip-flop bank with asynchronous active-low reset.
// Every bit is an independent flop. q_o comes straight from the flop, so
// there is no combinational path from d_i to q_o.
//
// Parameters
//   WIDTH    data path width, legal range 1..1024 (default 1)
//   RST_VAL  value held on q_o while rstn_i is low (default all zeros)
//
// Ports
//   clk_i    clock; state changes only on its rising edge
//   rstn_i   asynchronous reset, active low. Its release must meet
//            recovery/removal timing relative to clk_i.
//   d_i      data sampled on the rising edge of clk_i
//   q_o      registered data, one cycle of latency
//
// Configuration
//   DFF_POSEDGE_SYNC_ASSERT_EN  when defined, compiles in simulation
//                               assertions (reset value, one-cycle capture,
//                               no X/Z on d_i or rstn_i). The synthesized
//                               logic is the same whether or not it is
//                               defined.
// ---------------------------------------------------------------------------
module dff_posedge_sync #(
    parameter int unsigned           WIDTH   = 1,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Reset wins on every edge where rstn_i is low. Reset assertion acts
    // immediately; it does not wait for a clock edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

`ifdef DFF_POSEDGE_SYNC_ASSERT_EN
    // Sampled values are taken just before each edge. q_o sampled at an
    // edge therefore holds the value captured at the previous edge.
    a_reset_value : assert property (@(posedge clk_i) !rstn_i |-> (q_o === RST_VAL))
        else $error("%m: q_o=%h differs from RST_VAL=%h while in reset", q_o, RST_VAL);

    a_capture : assert property (@(posedge clk_i)
                                 (rstn_i && $past(rstn_i)) |-> (q_o === $past(d_i)))
        else $error("%m: q_o=%h differs from d_i of previous edge %h", q_o, $past(d_i));

    a_d_known : assert property (@(posedge clk_i) rstn_i |-> !$isunknown(d_i))
        else $error("%m: d_i has X/Z at a sampling edge");

    a_rstn_known : assert property (@(posedge clk_i) !$isunknown(rstn_i))
        else $error("%m: rstn_i has X/Z at a rising clock edge");

    // Asynchronous reset must reach q_o without waiting for a clock edge.
    always @(negedge rstn_i) begin
        #0;
        a_async_reset : assert (q_o === RST_VAL)
            else $error("%m: q_o=%h not at RST_VAL after reset assertion", q_o);
    end
`endif

endmodule

// File: tb/tb_dff_posedge_sync.sv
module tb_dff_posedge_sync;

    logic       clk;
    logic       rstn;
    logic       d1;
    logic       q1;
    logic [7:0] d8;
    logic [7:0] q8;

    int unsigned total;
    int unsigned passed;

    logic       exp1;
    logic [7:0] exp8;

    dff_posedge_sync u_dut1 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .d_i    (d1),
        .q_o    (q1)
    );

    dff_posedge_sync #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_dut8 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .d_i    (d8),
        .q_o    (q8)
    );

    // Posedges at 5, 15, 25 ... ; negedges at 10, 20, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rstn   = 1'b0;
        d1     = 1'b0;
        d8     = 8'h00;

        // Reset state at a clock edge
        @(posedge clk); #1;
        check("rst_q1", {7'b0, q1}, 8'h00);
        check("rst_q8", q8, 8'hA5);

        // Reset has priority over data capture
        @(negedge clk);
        d1 = 1'b1;
        d8 = 8'hFF;
        @(posedge clk); #1;
        check("rst_prio_q1", {7'b0, q1}, 8'h00);
        check("rst_prio_q8", q8, 8'hA5);

        // Release away from the edge; first edge loads d_i
        @(negedge clk);
        rstn = 1'b1;
        d1   = 1'b1;
        d8   = 8'h3C;
        #1;
        check("pre_edge_q1", {7'b0, q1}, 8'h00);
        check("pre_edge_q8", q8, 8'hA5);
        @(posedge clk); #1;
        check("cap1_q1", {7'b0, q1}, 8'h01);
        check("cap1_q8", q8, 8'h3C);

        // New data must wait for the next rising edge (falling edge ignored)
        @(negedge clk);
        d1 = 1'b0;
        d8 = 8'hC3;
        #1;
        check("negedge_hold_q1", {7'b0, q1}, 8'h01);
        check("negedge_hold_q8", q8, 8'h3C);
        @(posedge clk); #1;
        check("cap2_q1", {7'b0, q1}, 8'h00);
        check("cap2_q8", q8, 8'hC3);

        // Toggle d between edges: q holds
        #1 d1 = 1'b1; d8 = 8'h01;
        #1;
        check("hold_a_q1", {7'b0, q1}, 8'h00);
        check("hold_a_q8", q8, 8'hC3);
        d1 = 1'b0; d8 = 8'hFE;
        #1;
        check("hold_b_q1", {7'b0, q1}, 8'h00);
        check("hold_b_q8", q8, 8'hC3);
        @(negedge clk); #1;
        d1 = 1'b1; d8 = 8'h81;
        #1;
        check("hold_c_q1", {7'b0, q1}, 8'h00);
        check("hold_c_q8", q8, 8'hC3);
        @(posedge clk); #1;
        check("cap3_q1", {7'b0, q1}, 8'h01);
        check("cap3_q8", q8, 8'h81);

        // Unchanged d across an edge leaves q unchanged
        @(posedge clk); #1;
        check("same_q1", {7'b0, q1}, 8'h01);
        check("same_q8", q8, 8'h81);

        // Asynchronous reset mid-cycle, no clock edge involved
        #2 rstn = 1'b0;
        #1;
        check("async_q1", {7'b0, q1}, 8'h00);
        check("async_q8", q8, 8'hA5);

        // Stays in reset across an edge with live data
        @(posedge clk); #1;
        check("in_rst_q1", {7'b0, q1}, 8'h00);
        check("in_rst_q8", q8, 8'hA5);

        // Release again and capture
        @(negedge clk);
        rstn = 1'b1;
        d1   = 1'b1;
        d8   = 8'h5A;
        @(posedge clk); #1;
        check("rel2_q1", {7'b0, q1}, 8'h01);
        check("rel2_q8", q8, 8'h5A);

        // Random stream: q equals d from the previous edge
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            d1   = 1'($urandom);
            d8   = 8'($urandom);
            exp1 = d1;
            exp8 = d8;
            @(posedge clk); #1;
            check("rand_q1", {7'b0, q1}, {7'b0, exp1});
            check("rand_q8", q8, exp8);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
